// File: rtl/gpi_edge_core.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gpi_edge_core
//   General-purpose input slot core. Brings DATA_WIDTH asynchronous inputs
//   into the clock domain through a two-flop synchroniser. It captures
//   per-bit rising/falling edges into a sticky W1C register. It raises a
//   maskable level interrupt. It exposes six word registers on the slot
//   interface:
//     0 DATA (RO)   1 EDGE (R/W1C)   2 RISE_EN   3 FALL_EN   4 MASK
//     5 STATUS (RO, EDGE & MASK)     6..31 read 0, writes ignored
//
//   Optional build macro GPI_DEBOUNCE_EN:
//     Defining it inserts a tick-based debounce filter between the
//     synchroniser and the edge detector. A new level is accepted only after
//     DB_COUNT consecutive mismatching samples, taken every DB_TICK_DIV
//     cycles. Without it, the filtered level is the synchroniser output and
//     the DB_* parameters have no effect.
//
// Parameters
//   DATA_WIDTH   number of input bits (1..32)
//   DB_TICK_DIV  debounce sample period in clk cycles
//   DB_COUNT     consecutive equal samples needed to accept a level
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   cs        in   slot select
//   read      in   read strobe (reads have no side effects)
//   write     in   write strobe, effective when cs && write
//   reg_addr  in   [4:0] word register address
//   wr_data   in   [31:0] write data, bits above DATA_WIDTH ignored
//   rd_data   out  [31:0] combinational read data, zero-extended
//   irq       out  registered level interrupt
//   data_in   in   [DATA_WIDTH-1:0] asynchronous external inputs
// ---------------------------------------------------------------------------
module gpi_edge_core #(
    parameter int DATA_WIDTH  = 16,
    parameter int DB_TICK_DIV = 50000,
    parameter int DB_COUNT    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic                  read,
    input  logic                  write,
    input  logic [4:0]            reg_addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  irq,
    input  logic [DATA_WIDTH-1:0] data_in
);

    localparam int DW = DATA_WIDTH;

    localparam logic [4:0] ADDR_DATA    = 5'd0;
    localparam logic [4:0] ADDR_EDGE    = 5'd1;
    localparam logic [4:0] ADDR_RISE_EN = 5'd2;
    localparam logic [4:0] ADDR_FALL_EN = 5'd3;
    localparam logic [4:0] ADDR_MASK    = 5'd4;
    localparam logic [4:0] ADDR_STATUS  = 5'd5;

    // Place a DATA_WIDTH-bit register value into the low bits of a read word.
    function automatic logic [31:0] zext(input logic [DW-1:0] v);
        logic [31:0] r;
        r = 32'h0000_0000;
        r[DW-1:0] = v;
        return r;
    endfunction

    logic [DW-1:0] sync1_r;
    logic [DW-1:0] sync2_r;
    logic [DW-1:0] filtered_s;
    logic [DW-1:0] prev_r;
    logic [DW-1:0] edge_r;
    logic [DW-1:0] rise_en_r;
    logic [DW-1:0] fall_en_r;
    logic [DW-1:0] mask_r;
    logic          irq_r;

    logic          wr_en_s;
    logic [DW-1:0] wr_val_s;
    logic [DW-1:0] clr_s;
    logic [DW-1:0] rise_s;
    logic [DW-1:0] fall_s;
    logic [DW-1:0] edge_nxt_s;
    logic [DW-1:0] rise_en_nxt_s;
    logic [DW-1:0] fall_en_nxt_s;
    logic [DW-1:0] mask_nxt_s;

    // Two-flop synchroniser for the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {DW{1'b0}};
            sync2_r <= {DW{1'b0}};
        end else begin
            sync1_r <= data_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPI_DEBOUNCE_EN
    localparam int TICK_W = (DB_TICK_DIV > 1) ? $clog2(DB_TICK_DIV) : 1;
    localparam int CNT_W  = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DB_TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_COUNT - 1);

    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    logic [CNT_W-1:0]  db_cnt_r [DW];
    logic [CNT_W-1:0]  db_cnt_nxt_s [DW];
    logic [DW-1:0]     filtered_r;
    logic [DW-1:0]     filtered_nxt_s;
    logic              unused_s;

    assign unused_s = &{1'b0, read};

    // Sample strobe: one cycle high each time the free-running counter wraps.
    always_comb begin
        tick_s = (tick_cnt_r == TICK_LAST);
    end

    // Free-running debounce sample counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Per-bit agreement counter. The new level is accepted on the tick that
    // would take the counter past DB_COUNT-1 while the mismatch persists.
    always_comb begin
        filtered_nxt_s = filtered_r;
        for (int i = 0; i < DW; i++) begin
            db_cnt_nxt_s[i] = db_cnt_r[i];
            if (tick_s) begin
                if (sync2_r[i] != filtered_r[i]) begin
                    if (db_cnt_r[i] == CNT_LAST) begin
                        filtered_nxt_s[i] = sync2_r[i];
                        db_cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else begin
                        db_cnt_nxt_s[i]   = db_cnt_r[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt_nxt_s[i] = {CNT_W{1'b0}};
                end
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i];
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filtered_r <= {DW{1'b0}};
            for (int i = 0; i < DW; i++) begin
                db_cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            filtered_r <= filtered_nxt_s;
            for (int i = 0; i < DW; i++) begin
                db_cnt_r[i] <= db_cnt_nxt_s[i];
            end
        end
    end

    assign filtered_s = filtered_r;
`else
    logic unused_s;

    // Debounce parameters only matter when the filter is built.
    assign unused_s = &{1'b0, read, (DB_TICK_DIV > 0), (DB_COUNT > 0)};

    assign filtered_s = sync2_r;
`endif

    generate
        if (DW < 32) begin : g_wr_hi
            logic unused_hi_s;
            assign unused_hi_s = &{1'b0, wr_data[31:DW]};
        end
    endgenerate

    // Edge detection, W1C clear mask and next values of the writable registers.
    // A capture in the same cycle as a W1C of that bit keeps the bit set.
    always_comb begin
        wr_en_s       = cs & write;
        wr_val_s      = wr_data[DW-1:0];
        rise_s        = filtered_s & ~prev_r;
        fall_s        = ~filtered_s & prev_r;
        clr_s         = {DW{1'b0}};
        rise_en_nxt_s = rise_en_r;
        fall_en_nxt_s = fall_en_r;
        mask_nxt_s    = mask_r;
        if (wr_en_s) begin
            case (reg_addr)
                ADDR_EDGE:    clr_s         = wr_val_s;
                ADDR_RISE_EN: rise_en_nxt_s = wr_val_s;
                ADDR_FALL_EN: fall_en_nxt_s = wr_val_s;
                ADDR_MASK:    mask_nxt_s    = wr_val_s;
                default:      clr_s         = {DW{1'b0}};
            endcase
        end else begin
            clr_s = {DW{1'b0}};
        end
        edge_nxt_s = (edge_r & ~clr_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
    end

    // Edge history, capture/control registers and the registered interrupt.
    // prev restarts at 0 so the first post-reset cycle never sees stale levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r    <= {DW{1'b0}};
            edge_r    <= {DW{1'b0}};
            rise_en_r <= {DW{1'b0}};
            fall_en_r <= {DW{1'b0}};
            mask_r    <= {DW{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            prev_r    <= filtered_s;
            edge_r    <= edge_nxt_s;
            rise_en_r <= rise_en_nxt_s;
            fall_en_r <= fall_en_nxt_s;
            mask_r    <= mask_nxt_s;
            irq_r     <= |(edge_r & mask_r);
        end
    end

    // Read mux; the slot-level MMIO mux handles selection, so cs/read do not gate it.
    always_comb begin
        case (reg_addr)
            ADDR_DATA:    rd_data = zext(filtered_s);
            ADDR_EDGE:    rd_data = zext(edge_r);
            ADDR_RISE_EN: rd_data = zext(rise_en_r);
            ADDR_FALL_EN: rd_data = zext(fall_en_r);
            ADDR_MASK:    rd_data = zext(mask_r);
            ADDR_STATUS:  rd_data = zext(edge_r & mask_r);
            default:      rd_data = 32'h0000_0000;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_gpi_edge_core.sv
`timescale 1ns/1ps
// Self-checking bench for gpi_edge_core (DATA_WIDTH=16).
// Reference model: the filtered level is the input sampled two edges earlier.
// Edges are taken by comparing the input histories two and three edges back.
// All other state follows the register rules directly.
module tb_gpi_edge_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;
    logic [15:0] data_in;

    int checks = 0;
    int errors = 0;

    // model state
    logic [15:0] q[$];
    logic [15:0] m_edge, m_rise, m_fall, m_mask;
    logic        m_irq;
    logic [15:0] cur_din;

    always #20 clk = ~clk;

    gpi_edge_core #(
        .DATA_WIDTH (16),
        .DB_TICK_DIV(4),
        .DB_COUNT   (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .reg_addr(reg_addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq),
        .data_in (data_in)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        repeat (3) q.push_back(16'h0000);
        m_edge = 16'h0; m_rise = 16'h0; m_fall = 16'h0; m_mask = 16'h0;
        m_irq  = 1'b0;
    endfunction

    // One clock edge of the reference model, using the inputs driven into it.
    function automatic void model_edge();
        logic [15:0] nw, od, clr;
        logic        irq_n;
        q.push_back(data_in);
        while (q.size() > 4) void'(q.pop_front());
        nw    = q[q.size()-3];
        od    = q[q.size()-4];
        irq_n = |(m_edge & m_mask);
        clr   = (cs && write && reg_addr == 5'd1) ? wr_data[15:0] : 16'h0;
        m_edge = (m_edge & ~clr) | (nw & ~od & m_rise) | (~nw & od & m_fall);
        if (cs && write) begin
            case (reg_addr)
                5'd2: m_rise = wr_data[15:0];
                5'd3: m_fall = wr_data[15:0];
                5'd4: m_mask = wr_data[15:0];
                default: ;
            endcase
        end
        m_irq = irq_n;
    endfunction

    function automatic logic [31:0] exp_rd(input int a);
        case (a)
            0: return {16'h0, q[q.size()-2]};
            1: return {16'h0, m_edge};
            2: return {16'h0, m_rise};
            3: return {16'h0, m_fall};
            4: return {16'h0, m_mask};
            5: return {16'h0, m_edge & m_mask};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_all();
        for (int a = 0; a < 8; a++) begin
            reg_addr = 5'(a);
            #1;
            chk($sformatf("rd[%0d]", a), rd_data, exp_rd(a));
        end
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    // Drive one cycle (called in the low phase), clock it, model it, check at negedge.
    task automatic cycle(input logic [15:0] din, input logic wr, input logic [4:0] a,
                         input logic [31:0] wd);
        cur_din  = din;
        data_in  = din;
        cs       = wr;
        write    = wr;
        reg_addr = a;
        wr_data  = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cs    = 1'b0;
        write = 1'b0;
        check_all();
    endtask

    task automatic idle(input logic [15:0] din, input int n);
        for (int i = 0; i < n; i++) cycle(din, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        cycle(cur_din, 1'b1, a, d);
    endtask

    task automatic rd_now(input logic [4:0] a, output logic [31:0] v);
        reg_addr = a;
        #1;
        v = rd_data;
    endtask

    // Assert reset asynchronously in the low phase, hold it, release it.
    task automatic pulse_reset(input logic [15:0] din);
        reset_n = 1'b0;
        data_in = din;
        cur_din = din;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;
    endtask

`ifdef GPI_DEBOUNCE_EN
    task automatic raw_cycles(input logic [15:0] din, input int n);
        data_in = din;
        repeat (n) @(negedge clk);
    endtask
`endif

    initial begin
        logic [31:0] v;
        logic [15:0] d;
        logic        wr;
        logic [4:0]  a;
        logic [31:0] wd;
        int          waited;
        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        reg_addr = 5'd0; wr_data = 32'h0; data_in = 16'hFFFF; cur_din = 16'hFFFF;
        model_reset();
        @(negedge clk);

`ifdef GPI_DEBOUNCE_EN
        // Debounce: short glitch rejected, long level accepted.
        data_in = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        reg_addr = 5'd2; wr_data = 32'h1; cs = 1'b1; write = 1'b1;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        raw_cycles(16'h0000, 12);
        data_in = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_now(5'd0, v); chk("db_glitch_data", v, 32'h0);
        end
        data_in = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rd_now(5'd0, v); chk("db_glitch_data", v, 32'h0);
            rd_now(5'd1, v); chk("db_glitch_edge", v, 32'h0);
        end
        data_in = 16'h0001;
        raw_cycles(16'h0001, 20);
        waited = 0;
        rd_now(5'd0, v);
        while (v != 32'h1 && waited < 10) begin
            @(negedge clk);
            waited++;
            rd_now(5'd0, v);
        end
        chk("db_level_data", v, 32'h1);
        raw_cycles(16'h0001, 3);
        rd_now(5'd1, v); chk("db_level_edge", v, 32'h1);
`else
        // 1: reset holds everything at 0 even with inputs high.
        pulse_reset(16'hFFFF);
        idle(16'hFFFF, 2);
        rd_now(5'd0, v); chk("t1_data", v, 32'h0000FFFF);
        idle(16'hFFFF, 2);

        // 2: rising capture on bit 0, irq, then W1C.
        wr_reg(5'd2, 32'h1);
        wr_reg(5'd4, 32'h1);
        idle(16'h0000, 5);
        idle(16'h0001, 3);
        rd_now(5'd1, v); chk("t2_edge_k2", v, 32'h1);
        chk("t2_irq_k2", {31'h0, irq}, 32'h0);
        idle(16'h0001, 1);
        chk("t2_irq_k3", {31'h0, irq}, 32'h1);
        wr_reg(5'd1, 32'h1);
        rd_now(5'd1, v); chk("t2_edge_clr", v, 32'h0);
        idle(16'h0001, 1);
        chk("t2_irq_drop", {31'h0, irq}, 32'h0);

        // 3: falling capture on bit 15, masked then unmasked.
        wr_reg(5'd2, 32'h0);
        wr_reg(5'd3, 32'h8000);
        wr_reg(5'd4, 32'h0);
        idle(16'h8000, 4);
        wr_reg(5'd1, 32'hFFFF);
        idle(16'h0000, 4);
        rd_now(5'd1, v); chk("t3_edge", v, 32'h8000);
        rd_now(5'd5, v); chk("t3_status_m0", v, 32'h0);
        chk("t3_irq_m0", {31'h0, irq}, 32'h0);
        wr_reg(5'd4, 32'h8000);
        rd_now(5'd5, v); chk("t3_status_m1", v, 32'h8000);
        idle(16'h0000, 1);
        chk("t3_irq_m1", {31'h0, irq}, 32'h1);

        // 4: capture on bit 3 in the same cycle as its W1C.
        wr_reg(5'd3, 32'h0);
        wr_reg(5'd2, 32'h8);
        wr_reg(5'd4, 32'h0);
        idle(16'h0000, 4);
        wr_reg(5'd1, 32'hFFFF);
        idle(16'h0008, 2);
        cycle(16'h0008, 1'b1, 5'd1, 32'h8);
        rd_now(5'd1, v); chk("t4_edge3", v, 32'h8);

        // 5: toggling bit 1 with both enables, then writes to reg 7.
        wr_reg(5'd2, 32'h2);
        wr_reg(5'd3, 32'h2);
        wr_reg(5'd1, 32'hFFFF);
        d = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            d = d ^ 16'h0002;
            idle(d, 1);
        end
        idle(d, 3);
        rd_now(5'd1, v); chk("t5_edge1", {31'h0, v[1]}, 32'h1);
        for (int i = 0; i < 4; i++) wr_reg(5'd7, $urandom);

        // Randomised traffic with a mid-run reset.
        d = 16'(($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) d = 16'($urandom);
            wr = ($urandom_range(0, 2) == 0);
            a  = 5'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 5'd1 && $urandom_range(0, 1) == 0) wd = 32'hFFFF_FFFF;
            cycle(d, wr, a, wd);
            if (i == 200) pulse_reset(16'($urandom));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
